// File: rtl/uart_bridge_pkg.sv
// Shared constants, state encoding and helpers for the UART register bridge.
package uart_bridge_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned DVSR_W = 11;

    // Command opcodes
    localparam logic [BYTE_W-1:0] OP_WRITE    = 8'h57;  // 'W'
    localparam logic [BYTE_W-1:0] OP_READ     = 8'h52;  // 'R'

    // Reply bytes
    localparam logic [BYTE_W-1:0] RPL_ACK     = 8'h4B;  // 'K'
    localparam logic [BYTE_W-1:0] RPL_ERR     = 8'h3F;  // '?'
    localparam logic [BYTE_W-1:0] RPL_TIMEOUT = 8'h54;  // 'T'

    // Addresses served inside the bridge, never forwarded to the bus
    localparam logic [BYTE_W-1:0] ADDR_DVSR_LO = 8'hFE;
    localparam logic [BYTE_W-1:0] ADDR_DVSR_HI = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_ADDR = 3'd1,
        ST_GET_DATA = 3'd2,
        ST_BUS_WR   = 3'd3,
        ST_BUS_RD   = 3'd4,
        ST_RD_WAIT  = 3'd5,
        ST_SEND     = 3'd6
    } bridge_state_e;

    // True for addresses that map onto the divisor register.
    function automatic logic is_local_addr(input logic [BYTE_W-1:0] addr);
        return (addr == ADDR_DVSR_LO) || (addr == ADDR_DVSR_HI);
    endfunction

endpackage

// File: rtl/uart_bridge_timer.sv
// Inter-byte timeout counter: clear/increment with a terminal-count flag.
module uart_bridge_timer #(
    parameter int unsigned TIMEOUT = 1_000_000,
    parameter int unsigned TO_W    = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and hold at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_reg_bridge.sv
// Host command controller: RX bytes -> register bus access -> one TX reply byte.
module uart_reg_bridge
    import uart_bridge_pkg::*;
#(
    parameter int unsigned DVSR_RST = 650,
    parameter int unsigned TIMEOUT  = 1_000_000,
    parameter int unsigned TO_W     = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_empty,
    input  logic [BYTE_W-1:0] r_data,
    output logic              rd_uart,
    input  logic              tx_full,
    output logic [BYTE_W-1:0] w_data,
    output logic              wr_uart,
    output logic [DVSR_W-1:0] dvsr,
    output logic [BYTE_W-1:0] reg_addr,
    output logic [BYTE_W-1:0] reg_wdata,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [BYTE_W-1:0] reg_rdata,
    output logic              busy
);

    bridge_state_e     state_q;
    logic              busy_q;
    logic              op_wr_q;
    logic [BYTE_W-1:0] addr_q;
    logic [BYTE_W-1:0] data_q;
    logic [BYTE_W-1:0] reply_q;
    logic [BYTE_W-1:0] reg_addr_q;
    logic [BYTE_W-1:0] reg_wdata_q;
    logic              reg_wr_q;
    logic              reg_rd_q;
    logic [DVSR_W-1:0] dvsr_q;

    logic              consume_c;
    logic              wait_byte_c;
    logic              tmr_clr_c;
    logic              tmr_tc_c;

    // The FIFO head is combinational, so pop and push must follow the current cycle.
    assign consume_c   = (state_q == ST_IDLE) || (state_q == ST_GET_ADDR) ||
                         (state_q == ST_GET_DATA);
    assign wait_byte_c = (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA);
    assign rd_uart     = !reset && consume_c && !rx_empty;
    assign wr_uart     = !reset && (state_q == ST_SEND) && !tx_full;

    // Timer restarts whenever a wait state is entered or a byte arrives.
    assign tmr_clr_c = !wait_byte_c || !rx_empty;

    uart_bridge_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr_i (tmr_clr_c),
        .inc_i (rx_empty),
        .tc_o  (tmr_tc_c)
    );

    // Command sequencer with registered bus strobes, reply and divisor.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            op_wr_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            reply_q     <= '0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            dvsr_q      <= DVSR_W'(DVSR_RST);
        end else begin
            reg_wr_q <= 1'b0;
            reg_rd_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!rx_empty) begin
                        busy_q <= 1'b1;
                        if ((r_data == OP_WRITE) || (r_data == OP_READ)) begin
                            op_wr_q <= (r_data == OP_WRITE);
                            state_q <= ST_GET_ADDR;
                        end else begin
                            reply_q <= RPL_ERR;
                            state_q <= ST_SEND;
                        end
                    end
                end
                ST_GET_ADDR: begin
                    if (!rx_empty) begin
                        addr_q <= r_data;
                        if (op_wr_q) begin
                            state_q <= ST_GET_DATA;
                        end else begin
                            state_q <= ST_BUS_RD;
                            if (!is_local_addr(r_data)) begin
                                reg_addr_q <= r_data;
                                reg_rd_q   <= 1'b1;
                            end
                        end
                    end else if (tmr_tc_c) begin
                        reply_q <= RPL_TIMEOUT;
                        state_q <= ST_SEND;
                    end
                end
                ST_GET_DATA: begin
                    if (!rx_empty) begin
                        data_q  <= r_data;
                        state_q <= ST_BUS_WR;
                        if (!is_local_addr(addr_q)) begin
                            reg_addr_q  <= addr_q;
                            reg_wdata_q <= r_data;
                            reg_wr_q    <= 1'b1;
                        end
                    end else if (tmr_tc_c) begin
                        reply_q <= RPL_TIMEOUT;
                        state_q <= ST_SEND;
                    end
                end
                ST_BUS_WR: begin
                    // Bus strobe is already out; local writes land here.
                    if (addr_q == ADDR_DVSR_LO) begin
                        dvsr_q[7:0] <= data_q;
                    end else if (addr_q == ADDR_DVSR_HI) begin
                        dvsr_q[10:8] <= data_q[2:0];
                    end
                    reply_q <= RPL_ACK;
                    state_q <= ST_SEND;
                end
                ST_BUS_RD: begin
                    state_q <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (addr_q == ADDR_DVSR_LO) begin
                        reply_q <= dvsr_q[7:0];
                    end else if (addr_q == ADDR_DVSR_HI) begin
                        reply_q <= {5'b0, dvsr_q[10:8]};
                    end else begin
                        reply_q <= reg_rdata;
                    end
                    state_q <= ST_SEND;
                end
                ST_SEND: begin
                    if (!tx_full) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_data    = reply_q;
    assign dvsr      = dvsr_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_wr    = reg_wr_q;
    assign reg_rd    = reg_rd_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed bench for uart_reg_bridge with FIFO and register bus models.
module tb_uart_reg_bridge;

    localparam int unsigned TO_LIM = 64;

    logic        clk;
    logic        reset;
    logic        rx_empty;
    logic [7:0]  r_data;
    logic        rd_uart;
    logic        tx_full;
    logic [7:0]  w_data;
    logic        wr_uart;
    logic [10:0] dvsr;
    logic [7:0]  reg_addr;
    logic [7:0]  reg_wdata;
    logic        reg_wr;
    logic        reg_rd;
    logic [7:0]  reg_rdata;
    logic        busy;

    uart_reg_bridge #(
        .DVSR_RST (650),
        .TIMEOUT  (TO_LIM),
        .TO_W     (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_empty  (rx_empty),
        .r_data    (r_data),
        .rd_uart   (rd_uart),
        .tx_full   (tx_full),
        .w_data    (w_data),
        .wr_uart   (wr_uart),
        .dvsr      (dvsr),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    int          cyc = 0;
    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    logic [15:0] wr_log[$];
    logic [7:0]  rd_log[$];
    int          pop_cyc[$];
    int          wr_cyc[$];
    int          regwr_cyc[$];
    int          regrd_cyc[$];
    int          rd_empty_err = 0;
    int          wr_full_err  = 0;
    int          both_err     = 0;
    logic [7:0]  bus_rdata    = 8'h3C;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // FIFO / bus model: observe at negedge, update inputs just after posedge.
    initial begin
        logic pop_pending;
        logic rd_seen;
        pop_pending = 1'b0;
        rd_seen     = 1'b0;
        rx_empty    = 1'b1;
        r_data      = 8'h00;
        reg_rdata   = 8'hEE;
        forever begin
            @(negedge clk);
            if (rd_uart) begin
                if (rx_empty) rd_empty_err++;
                else begin
                    pop_pending = 1'b1;
                    pop_cyc.push_back(cyc);
                end
            end
            if (wr_uart) begin
                if (tx_full) wr_full_err++;
                txq.push_back(w_data);
                wr_cyc.push_back(cyc);
            end
            if (reg_wr && reg_rd) both_err++;
            if (reg_wr) begin
                wr_log.push_back({reg_addr, reg_wdata});
                regwr_cyc.push_back(cyc);
            end
            if (reg_rd) begin
                rd_log.push_back(reg_addr);
                regrd_cyc.push_back(cyc);
            end
            rd_seen = reg_rd;
            @(posedge clk);
            #1;
            cyc++;
            if (pop_pending && rxq.size() > 0) void'(rxq.pop_front());
            pop_pending = 1'b0;
            rx_empty  = (rxq.size() == 0);
            r_data    = rx_empty ? 8'h00 : rxq[0];
            reg_rdata = rd_seen ? bus_rdata : 8'hEE;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_logs();
        txq.delete();
        wr_log.delete();
        rd_log.delete();
        pop_cyc.delete();
        wr_cyc.delete();
        regwr_cyc.delete();
        regrd_cyc.delete();
    endtask

    task automatic push3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input int n);
        rxq.push_back(a);
        if (n > 1) rxq.push_back(b);
        if (n > 2) rxq.push_back(c);
    endtask

    task automatic wait_tx(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (txq.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check_eq(tag, txq.size(), n);
        tick(2);
    endtask

    task automatic wait_pops(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (pop_cyc.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check_eq(tag, pop_cyc.size(), n);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rd_uart"},   rd_uart,   0);
        check_eq({tag, "_wr_uart"},   wr_uart,   0);
        check_eq({tag, "_w_data"},    w_data,    0);
        check_eq({tag, "_reg_addr"},  reg_addr,  0);
        check_eq({tag, "_reg_wdata"}, reg_wdata, 0);
        check_eq({tag, "_reg_wr"},    reg_wr,    0);
        check_eq({tag, "_reg_rd"},    reg_rd,    0);
        check_eq({tag, "_busy"},      busy,      0);
        check_eq({tag, "_dvsr"},      dvsr,      650);
    endtask

    initial begin
        int target;
        reset   = 1'b1;
        tx_full = 1'b0;
        tick(3);
        check_reset_outputs("rst");
        reset = 1'b0;
        tick(2);
        check_eq("idle_busy", busy, 0);

        // Bus write
        clear_logs();
        push3(8'h57, 8'h10, 8'hA5, 3);
        wait_tx(1, 50, "wr_tx_cnt");
        check_eq("wr_reply", txq[0], 8'h4B);
        check_eq("wr_strobes", wr_log.size(), 1);
        check_eq("wr_addr_data", wr_log[0], 16'h10A5);
        check_eq("wr_no_rd", rd_log.size(), 0);
        check_eq("wr_strobe_lat", regwr_cyc[0] - pop_cyc[2], 1);
        check_eq("wr_reply_lat", wr_cyc[0] - pop_cyc[2], 2);

        // Bus read
        clear_logs();
        bus_rdata = 8'h3C;
        push3(8'h52, 8'h10, 8'h00, 2);
        wait_tx(1, 50, "rd_tx_cnt");
        check_eq("rd_reply", txq[0], 8'h3C);
        check_eq("rd_strobes", rd_log.size(), 1);
        check_eq("rd_addr", rd_log[0], 8'h10);
        check_eq("rd_no_wr", wr_log.size(), 0);
        check_eq("rd_strobe_lat", regrd_cyc[0] - pop_cyc[1], 1);
        check_eq("rd_reply_lat", wr_cyc[0] - pop_cyc[1], 3);

        // Local divisor writes and reads
        clear_logs();
        push3(8'h57, 8'hFE, 8'h40, 3);
        push3(8'h57, 8'hFF, 8'h01, 3);
        wait_tx(2, 80, "loc_tx_cnt");
        check_eq("loc_reply0", txq[0], 8'h4B);
        check_eq("loc_reply1", txq[1], 8'h4B);
        check_eq("loc_dvsr", dvsr, 11'h140);
        clear_logs();
        push3(8'h52, 8'hFF, 8'h00, 2);
        push3(8'h52, 8'hFE, 8'h00, 2);
        wait_tx(2, 80, "locrd_tx_cnt");
        check_eq("locrd_hi", txq[0], 8'h01);
        check_eq("locrd_lo", txq[1], 8'h40);
        check_eq("locrd_lat", wr_cyc[0] - pop_cyc[1], 3);
        check_eq("loc_no_wr", wr_log.size(), 0);
        check_eq("loc_no_rd", rd_log.size(), 0);
        check_eq("hold_addr", reg_addr, 8'h10);
        check_eq("hold_wdata", reg_wdata, 8'hA5);

        // Unknown opcode
        clear_logs();
        push3(8'h00, 8'h00, 8'h00, 1);
        wait_tx(1, 20, "unk_tx_cnt");
        check_eq("unk_reply", txq[0], 8'h3F);
        check_eq("unk_lat", wr_cyc[0] - pop_cyc[0], 1);

        // Timeout waiting for the data byte
        clear_logs();
        push3(8'h57, 8'h10, 8'h00, 2);
        wait_tx(1, TO_LIM + 40, "to_tx_cnt");
        check_eq("to_reply", txq[0], 8'h54);
        check_eq("to_no_wr", wr_log.size(), 0);
        check_eq("to_lat", wr_cyc[0] - pop_cyc[1], TO_LIM + 1);
        clear_logs();
        push3(8'h57, 8'h20, 8'h5A, 3);
        wait_tx(1, 50, "after_to_cnt");
        check_eq("after_to_reply", txq[0], 8'h4B);
        check_eq("after_to_wr", wr_log[0], 16'h205A);

        // Data byte arriving in the very cycle the limit is reached
        clear_logs();
        push3(8'h57, 8'h30, 8'h00, 2);
        wait_pops(2, 20, "edge_pops");
        target = pop_cyc[1] + TO_LIM - 1;
        while (cyc < target) tick(1);
        rxq.push_back(8'h77);
        wait_tx(1, 40, "edge_tx_cnt");
        check_eq("edge_reply", txq[0], 8'h4B);
        check_eq("edge_wr", wr_log.size(), 1);

        // TX back-pressure with the next command queued
        clear_logs();
        tx_full = 1'b1;
        push3(8'h00, 8'h00, 8'h00, 1);
        push3(8'h52, 8'h10, 8'h00, 2);
        tick(50);
        check_eq("bp_no_tx", txq.size(), 0);
        check_eq("bp_one_pop", pop_cyc.size(), 1);
        tx_full = 1'b0;
        wait_tx(2, 50, "bp_tx_cnt");
        check_eq("bp_reply0", txq[0], 8'h3F);
        check_eq("bp_reply1", txq[1], 8'h3C);

        // Reset in the middle of a command
        clear_logs();
        push3(8'h57, 8'h10, 8'h00, 2);
        wait_pops(2, 20, "mid_pops");
        tick(2);
        check_eq("mid_busy", busy, 1);
        reset = 1'b1;
        rxq.delete();
        tick(2);
        check_reset_outputs("mid_rst");
        reset = 1'b0;
        tick(3);
        check_eq("mid_busy_after", busy, 0);
        check_eq("mid_no_tx", txq.size(), 0);
        check_eq("mid_no_wr", wr_log.size(), 0);
        clear_logs();
        push3(8'h57, 8'h11, 8'h22, 3);
        wait_tx(1, 50, "post_rst_cnt");
        check_eq("post_rst_reply", txq[0], 8'h4B);
        check_eq("post_rst_wr", wr_log[0], 16'h1122);

        check_eq("no_pop_when_empty", rd_empty_err, 0);
        check_eq("no_push_when_full", wr_full_err, 0);
        check_eq("no_wr_rd_overlap", both_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
